pipe_hazard_ctrl: RTL

//  Stall/flush controller for the 5-stage pipeline. It compares ID-stage source registers
//  and their Tuse against EX/MEM destinations and their Tnew. It also tracks the

---
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush controller for the 5-stage pipeline. Detects RAW hazards by
// comparing ID-stage sources (and the cycle each one is needed) against the
// EX/MEM destinations (and the cycle each result becomes available). Tracks
// the multi-cycle mult/div unit with a small IDLE/BUSY FSM, so that MD-class
// instructions wait until the unit is free.
// Optional feature: define STALL_CNT_EN to build a saturating 32-bit
// stall-cycle counter; otherwise stall_cnt is a constant zero.
// MULT_LAT and DIV_LAT must be non-zero, and 2**CNT_W must exceed both.

module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [1:0]  id_tuse_rs,
  input  logic [1:0]  id_tuse_rt,
  input  logic        id_is_md,
  input  logic [4:0]  ex_regaddr,
  input  logic [1:0]  ex_tnew,
  input  logic [4:0]  mem_regaddr,
  input  logic [1:0]  mem_tnew,
  input  logic        ex_md_start,
  input  logic        ex_md_div,
  output logic        stall,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             md_last;

  logic stall_rs;
  logic stall_rt;
  logic md_busy_raw;
  logic stall_raw;

  // A source stalls when a producer in EX or MEM will not have its result
  // ready by the time this instruction needs it; $0 is hardwired and never waits.
  always_comb begin
    stall_rs = (id_rs != 5'd0) &&
               (((id_rs == ex_regaddr)  && (id_tuse_rs < ex_tnew)) ||
                ((id_rs == mem_regaddr) && (id_tuse_rs < mem_tnew)));
    stall_rt = (id_rt != 5'd0) &&
               (((id_rt == ex_regaddr)  && (id_tuse_rt < ex_tnew)) ||
                ((id_rt == mem_regaddr) && (id_tuse_rt < mem_tnew)));
  end

  // MD unit tracker: load the latency on a start from IDLE, count down in BUSY.
  // md_last is precomputed one edge early so md_done comes straight from a flop.
  // A start seen while BUSY is deliberately ignored (no reload).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      md_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_md_start) begin
            state <= BUSY;
            if (ex_md_div) begin
              cnt     <= CNT_W'(DIV_LAT);
              md_last <= (DIV_LAT == 1);
            end else begin
              cnt     <= CNT_W'(MULT_LAT);
              md_last <= (MULT_LAT == 1);
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= IDLE;
            md_last <= 1'b0;
          end else begin
            md_last <= (cnt == CNT_W'(2));
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          md_last <= 1'b0;
        end
      endcase
    end
  end

  // Combine hazard sources; every output is held at its idle value while
  // reset is low, regardless of what the pipeline is presenting.
  always_comb begin
    md_busy_raw = (state == BUSY) || ex_md_start;
    stall_raw   = stall_rs || stall_rt || (id_is_md && md_busy_raw);
    stall       = reset && stall_raw;
    pc_en       = !stall;
    ifid_en     = !stall;
    idex_flush  = stall;
    md_busy     = reset && md_busy_raw;
    md_done     = reset && md_last;
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Performance counter of stalled cycles, saturating instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
